rvfi_htif_ctrl: RTL and testbench

Host-target interface (HTIF) controller for the CVA6 testbench. It watches committed stores on all RVFI commit ports for writes to `tohost` and arbitrates between ports that hit in the same cycle. It then either terminates the test with an exit code, or sequences a syscall: hand-off to the host-side handler, wait for the response, write the result to `fromhost`. It sits beside the RVFI tracer in the testbench and replaces ad-hoc termination and syscall logic with a single handshaked scheduler, including the simulation timeout.

---
 rtl/htif_pkg.sv | 24 ++
 rtl/rvfi_htif_ctrl_if.sv | 39 +++
 rtl/htif_port_arb.sv | 52 +++++
 rtl/rvfi_htif_ctrl.sv | 148 ++++++++++++++
 tb/tb_rvfi_htif_ctrl.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/htif_pkg.sv
// Shared types and constants for the HTIF controller: FSM states, the
// timeout exit code and the per-port committed-store record.
package htif_pkg;

  localparam int unsigned HTIF_PLEN = 56;
  localparam int unsigned HTIF_XLEN = 64;

  localparam logic [31:0] HTIF_TIMEOUT_CODE = 32'hffff_ffff;

  typedef enum logic [2:0] {
    HTIF_IDLE,
    HTIF_REQ,
    HTIF_WAIT_RSP,
    HTIF_WR_FH,
    HTIF_DONE
  } htif_state_e;

  typedef struct packed {
    logic                 valid;
    logic [HTIF_PLEN-1:0] paddr;
    logic [HTIF_XLEN-1:0] wdata;
  } htif_store_t;

endpackage

// File: rtl/rvfi_htif_ctrl_if.sv
// Host-side handshakes of the HTIF controller: syscall request/response
// towards the host handler and the fromhost write towards memory.
interface rvfi_htif_ctrl_if
  import htif_pkg::*;
#(
  parameter int unsigned PLEN = HTIF_PLEN,
  parameter int unsigned XLEN = HTIF_XLEN
) ();

  // Valid/ready: a transfer happens on a cycle where valid && ready; the
  // source keeps valid and its payload stable until then. sys_rsp_valid_i
  // is a single-cycle pulse with no back-pressure.
  logic            sys_req_valid_o;
  logic [XLEN-1:0] sys_req_data_o;
  logic            sys_req_ready_i;
  logic            sys_rsp_valid_i;
  logic [XLEN-1:0] sys_rsp_data_i;
  logic            fh_wr_valid_o;
  logic [PLEN-1:0] fh_wr_addr_o;
  logic [XLEN-1:0] fh_wr_data_o;
  logic            fh_wr_ready_i;

  modport master (
    output sys_req_valid_o, sys_req_data_o,
    input  sys_req_ready_i,
    input  sys_rsp_valid_i, sys_rsp_data_i,
    output fh_wr_valid_o, fh_wr_addr_o, fh_wr_data_o,
    input  fh_wr_ready_i
  );

  modport slave (
    input  sys_req_valid_o, sys_req_data_o,
    output sys_req_ready_i,
    output sys_rsp_valid_i, sys_rsp_data_i,
    input  fh_wr_valid_o, fh_wr_addr_o, fh_wr_data_o,
    output fh_wr_ready_i
  );

endinterface

// File: rtl/htif_port_arb.sv
// Combinational tohost hit detection and lowest-index priority select over
// the RVFI commit ports (lower index is older in program order).
module htif_port_arb
  import htif_pkg::*;
#(
  parameter  int unsigned NrPorts = 2,
  localparam int unsigned IdxW    = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
  input  htif_store_t          store [NrPorts],
  input  logic [HTIF_PLEN-1:0] tohost_addr,
  output logic                 hit,
  output logic [IdxW-1:0]      win_idx,
  output logic [HTIF_XLEN-1:0] win_data,
  output logic                 multi_hit,
  output logic                 exit_hit,
  output logic [31:0]          exit_code
);

  logic [NrPorts-1:0] port_hit;

  for (genvar g = 0; g < NrPorts; g++) begin : g_hit
    assign port_hit[g] = store[g].valid && (tohost_addr != '0) &&
                         (store[g].paddr == tohost_addr);
  end

  // exit_hit/exit_code track the oldest terminating store separately, since
  // a busy FSM honours exits even when the overall winner is a syscall.
  always_comb begin
    hit       = 1'b0;
    win_idx   = '0;
    win_data  = '0;
    multi_hit = 1'b0;
    exit_hit  = 1'b0;
    exit_code = '0;
    for (int i = 0; i < NrPorts; i++) begin
      if (port_hit[i]) begin
        if (hit) begin
          multi_hit = 1'b1;
        end else begin
          hit      = 1'b1;
          win_idx  = IdxW'(i);
          win_data = store[i].wdata;
        end
        if (!exit_hit && store[i].wdata[0]) begin
          exit_hit  = 1'b1;
          exit_code = store[i].wdata[31:0];
        end
      end
    end
  end

endmodule

// File: rtl/rvfi_htif_ctrl.sv
// HTIF controller: watches committed stores for tohost writes, terminates
// the test or sequences a syscall round trip, and enforces the cycle limit.
module rvfi_htif_ctrl
  import htif_pkg::*;
#(
  parameter  int unsigned NrPorts = 2,
  parameter  int unsigned PLEN    = HTIF_PLEN,
  parameter  int unsigned XLEN    = HTIF_XLEN,
  localparam int unsigned IdxW    = (NrPorts > 1) ? $clog2(NrPorts) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [PLEN-1:0]                tohost_addr_i,
  input  logic [PLEN-1:0]                fromhost_addr_i,
  input  logic [31:0]                    timeout_i,
  input  logic [NrPorts-1:0]             st_valid_i,
  input  logic [NrPorts-1:0][PLEN-1:0]   st_paddr_i,
  input  logic [NrPorts-1:0][XLEN-1:0]   st_wdata_i,
  rvfi_htif_ctrl_if.master               host,
  output logic [31:0]                    end_of_test_o,
  output logic                           busy_o,
  output logic                           overrun_o,
  output htif_state_e                    dbg_state_o,
  output logic [IdxW-1:0]                dbg_last_port_o
);

  htif_store_t          store [NrPorts];
  logic                 hit, multi_hit, exit_hit;
  logic [IdxW-1:0]      win_idx;
  logic [HTIF_XLEN-1:0] win_data;
  logic [31:0]          exit_code;

  for (genvar g = 0; g < NrPorts; g++) begin : g_store
    assign store[g].valid = st_valid_i[g];
    assign store[g].paddr = HTIF_PLEN'(st_paddr_i[g]);
    assign store[g].wdata = HTIF_XLEN'(st_wdata_i[g]);
  end

  htif_port_arb #(.NrPorts(NrPorts)) u_arb (
    .store       (store),
    .tohost_addr (HTIF_PLEN'(tohost_addr_i)),
    .hit         (hit),
    .win_idx     (win_idx),
    .win_data    (win_data),
    .multi_hit   (multi_hit),
    .exit_hit    (exit_hit),
    .exit_code   (exit_code)
  );

  htif_state_e     state_q, state_d;
  logic [31:0]     eot_q, eot_d;
  logic [XLEN-1:0] req_data_q, req_data_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic [PLEN-1:0] fh_addr_q, fh_addr_d;
  logic            overrun_q, overrun_d;
  logic [IdxW-1:0] last_port_q, last_port_d;
  logic [31:0]     cycles_q;
  logic            timeout_hit;

  assign timeout_hit = (timeout_i != '0) && (cycles_q > timeout_i);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= HTIF_IDLE;
      eot_q       <= '0;
      req_data_q  <= '0;
      rsp_data_q  <= '0;
      fh_addr_q   <= '0;
      overrun_q   <= 1'b0;
      last_port_q <= '0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      eot_q       <= eot_d;
      req_data_q  <= req_data_d;
      rsp_data_q  <= rsp_data_d;
      fh_addr_q   <= fh_addr_d;
      overrun_q   <= overrun_d;
      last_port_q <= last_port_d;
      if (cycles_q != 32'hffff_ffff) cycles_q <= cycles_q + 32'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    eot_d       = eot_q;
    req_data_d  = req_data_q;
    rsp_data_d  = rsp_data_q;
    fh_addr_d   = fh_addr_q;
    overrun_d   = overrun_q;
    last_port_d = last_port_q;

    unique case (state_q)
      HTIF_IDLE: begin
        if (hit) begin
          if (multi_hit) overrun_d = 1'b1;
          last_port_d = win_idx;
          if (win_data[0]) begin
            eot_d   = win_data[31:0];
            state_d = HTIF_DONE;
          end else begin
            req_data_d = win_data[XLEN-1:0];
            state_d    = HTIF_REQ;
          end
        end
      end
      HTIF_REQ, HTIF_WAIT_RSP, HTIF_WR_FH: begin
        // Every hit except the one terminating store is dropped here.
        if (hit && (!exit_hit || multi_hit)) overrun_d = 1'b1;
        if (exit_hit) begin
          eot_d   = exit_code;
          state_d = HTIF_DONE;
        end else if (state_q == HTIF_REQ) begin
          if (host.sys_req_ready_i) state_d = HTIF_WAIT_RSP;
        end else if (state_q == HTIF_WAIT_RSP) begin
          if (host.sys_rsp_valid_i) begin
            rsp_data_d = host.sys_rsp_data_i;
            fh_addr_d  = fromhost_addr_i;
            state_d    = HTIF_WR_FH;
          end
        end else begin
          if (host.fh_wr_ready_i) state_d = HTIF_IDLE;
        end
      end
      HTIF_DONE: ;
      default: state_d = HTIF_IDLE;
    endcase

    // An exit decided above already moved to DONE, so it outranks the timeout.
    if (state_q != HTIF_DONE && state_d != HTIF_DONE && timeout_hit) begin
      eot_d   = HTIF_TIMEOUT_CODE;
      state_d = HTIF_DONE;
    end
  end

  assign host.sys_req_valid_o = (state_q == HTIF_REQ);
  assign host.sys_req_data_o  = req_data_q;
  assign host.fh_wr_valid_o   = (state_q == HTIF_WR_FH);
  assign host.fh_wr_addr_o    = fh_addr_q;
  assign host.fh_wr_data_o    = rsp_data_q;

  assign end_of_test_o   = eot_q;
  assign busy_o          = (state_q != HTIF_IDLE);
  assign overrun_o       = overrun_q;
  assign dbg_state_o     = state_q;
  assign dbg_last_port_o = last_port_q;

endmodule

// File: tb/tb_rvfi_htif_ctrl.sv
// Directed bench for rvfi_htif_ctrl: exit, syscall round trips, arbitration,
// overrun, timeout, reset abort and disabled matching.
module tb_rvfi_htif_ctrl;
  import htif_pkg::*;

  localparam int unsigned NP   = 2;
  localparam int unsigned PL   = 56;
  localparam int unsigned XL   = 64;
  localparam logic [PL-1:0] TOHOST   = 56'h8000_1000;
  localparam logic [PL-1:0] FROMHOST = 56'h8000_1040;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [PL-1:0]           tohost_addr = TOHOST;
  logic [PL-1:0]           fromhost_addr = FROMHOST;
  logic [31:0]             timeout = '0;
  logic [NP-1:0]           st_valid = '0;
  logic [NP-1:0][PL-1:0]   st_paddr = '0;
  logic [NP-1:0][XL-1:0]   st_wdata = '0;
  logic [31:0]             end_of_test;
  logic                    busy, overrun;
  htif_state_e             dbg_state;
  logic [0:0]              dbg_last_port;

  int n_vec = 0;
  int n_err = 0;
  logic [XL-1:0] exp_q[$];

  rvfi_htif_ctrl_if #(.PLEN(PL), .XLEN(XL)) host_if ();

  rvfi_htif_ctrl #(.NrPorts(NP), .PLEN(PL), .XLEN(XL)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .tohost_addr_i   (tohost_addr),
    .fromhost_addr_i (fromhost_addr),
    .timeout_i       (timeout),
    .st_valid_i      (st_valid),
    .st_paddr_i      (st_paddr),
    .st_wdata_i      (st_wdata),
    .host            (host_if.master),
    .end_of_test_o   (end_of_test),
    .busy_o          (busy),
    .overrun_o       (overrun),
    .dbg_state_o     (dbg_state),
    .dbg_last_port_o (dbg_last_port)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    st_valid = '0;
    host_if.sys_req_ready_i = 1'b0;
    host_if.sys_rsp_valid_i = 1'b0;
    host_if.sys_rsp_data_i  = '0;
    host_if.fh_wr_ready_i   = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic put_store(input int port, input logic [PL-1:0] addr, input logic [XL-1:0] data);
    st_valid[port] = 1'b1;
    st_paddr[port] = addr;
    st_wdata[port] = data;
  endtask

  task automatic clear_stores();
    st_valid = '0;
  endtask

  // ---------------- fromhost scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && host_if.fh_wr_valid_o && host_if.fh_wr_ready_i) begin
      if (exp_q.size() == 0) begin
        check("fh_unexpected_write", 64'(host_if.fh_wr_data_o), 64'h0);
      end else begin
        logic [XL-1:0] e;
        e = exp_q.pop_front();
        check("fh_data", 64'(host_if.fh_wr_data_o), 64'(e));
        check("fh_addr", 64'(host_if.fh_wr_addr_o), 64'(FROMHOST));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    do_reset();

    // Reset state
    check("rst_eot",      64'(end_of_test), 64'h0);
    check("rst_req_valid", 64'(host_if.sys_req_valid_o), 64'h0);
    check("rst_req_data", 64'(host_if.sys_req_data_o), 64'h0);
    check("rst_fh_valid", 64'(host_if.fh_wr_valid_o), 64'h0);
    check("rst_busy",     64'(busy), 64'h0);
    check("rst_overrun",  64'(overrun), 64'h0);
    check("rst_state",    64'(dbg_state), 64'(HTIF_IDLE));

    // Exit from port 0
    put_store(0, TOHOST, 64'h1);
    step(1);
    clear_stores();
    check("exit_eot",   64'(end_of_test), 64'h1);
    check("exit_state", 64'(dbg_state), 64'(HTIF_DONE));
    put_store(1, TOHOST, 64'h8000_2000);
    put_store(0, TOHOST, 64'h9);
    step(1);
    clear_stores();
    check("done_eot",       64'(end_of_test), 64'h1);
    check("done_req_valid", 64'(host_if.sys_req_valid_o), 64'h0);
    check("done_overrun",   64'(overrun), 64'h0);

    // Syscall round trip on port 1, ready after 3 cycles
    do_reset();
    put_store(1, TOHOST, 64'h8000_2000);
    step(1);
    clear_stores();
    check("sc_req_valid", 64'(host_if.sys_req_valid_o), 64'h1);
    check("sc_req_data",  64'(host_if.sys_req_data_o), 64'h8000_2000);
    check("sc_last_port", 64'(dbg_last_port), 64'h1);
    check("sc_eot",       64'(end_of_test), 64'h0);
    step(2);
    check("sc_req_hold",  64'(host_if.sys_req_valid_o), 64'h1);
    check("sc_data_hold", 64'(host_if.sys_req_data_o), 64'h8000_2000);
    host_if.sys_req_ready_i = 1'b1;
    step(1);
    host_if.sys_req_ready_i = 1'b0;
    check("sc_req_drop",  64'(host_if.sys_req_valid_o), 64'h0);
    check("sc_wait",      64'(dbg_state), 64'(HTIF_WAIT_RSP));
    step(1);
    check("sc_no_fh_yet", 64'(host_if.fh_wr_valid_o), 64'h0);
    exp_q.push_back(64'h2A);
    host_if.sys_rsp_valid_i = 1'b1;
    host_if.sys_rsp_data_i  = 64'h2A;
    step(1);
    host_if.sys_rsp_valid_i = 1'b0;
    host_if.sys_rsp_data_i  = 64'hdead;
    check("sc_fh_valid", 64'(host_if.fh_wr_valid_o), 64'h1);
    check("sc_fh_data",  64'(host_if.fh_wr_data_o), 64'h2A);
    check("sc_fh_addr",  64'(host_if.fh_wr_addr_o), 64'(FROMHOST));
    step(1);
    check("sc_fh_hold",  64'(host_if.fh_wr_valid_o), 64'h1);
    host_if.fh_wr_ready_i = 1'b1;
    step(1);
    host_if.fh_wr_ready_i = 1'b0;
    check("sc_idle",     64'(dbg_state), 64'(HTIF_IDLE));
    check("sc_fh_drop",  64'(host_if.fh_wr_valid_o), 64'h0);
    check("sc_fh_count", 64'(exp_q.size()), 64'h0);

    // Back-to-back syscall at minimum turnaround (3 cycles hit to fh valid)
    host_if.sys_req_ready_i = 1'b1;
    host_if.fh_wr_ready_i   = 1'b1;
    put_store(0, TOHOST, 64'h8000_2100);
    step(1);
    clear_stores();
    check("b2b_req_valid", 64'(host_if.sys_req_valid_o), 64'h1);
    check("b2b_req_data",  64'(host_if.sys_req_data_o), 64'h8000_2100);
    step(1);
    host_if.sys_req_ready_i = 1'b0;
    exp_q.push_back(64'h77);
    host_if.sys_rsp_valid_i = 1'b1;
    host_if.sys_rsp_data_i  = 64'h77;
    step(1);
    host_if.sys_rsp_valid_i = 1'b0;
    check("b2b_fh_valid", 64'(host_if.fh_wr_valid_o), 64'h1);
    step(1);
    host_if.fh_wr_ready_i = 1'b0;
    check("b2b_idle",     64'(dbg_state), 64'(HTIF_IDLE));
    check("b2b_fh_count", 64'(exp_q.size()), 64'h0);

    // Same-cycle hits: port 0 syscall wins, port 1 exit dropped
    do_reset();
    put_store(0, TOHOST, 64'h8000_3000);
    put_store(1, TOHOST, 64'h5);
    step(1);
    clear_stores();
    check("mh_req_valid", 64'(host_if.sys_req_valid_o), 64'h1);
    check("mh_req_data",  64'(host_if.sys_req_data_o), 64'h8000_3000);
    check("mh_overrun",   64'(overrun), 64'h1);
    check("mh_eot",       64'(end_of_test), 64'h0);
    check("mh_last_port", 64'(dbg_last_port), 64'h0);

    // Busy: syscall hit dropped with overrun, exit still terminates
    do_reset();
    put_store(0, TOHOST, 64'h100);
    step(1);
    clear_stores();
    check("bz_overrun0", 64'(overrun), 64'h0);
    put_store(0, TOHOST, 64'h200);
    step(1);
    clear_stores();
    check("bz_overrun1", 64'(overrun), 64'h1);
    check("bz_req_data", 64'(host_if.sys_req_data_o), 64'h100);
    check("bz_state",    64'(dbg_state), 64'(HTIF_REQ));
    put_store(1, TOHOST, 64'h7);
    step(1);
    clear_stores();
    check("bz_exit_eot",   64'(end_of_test), 64'h7);
    check("bz_exit_valid", 64'(host_if.sys_req_valid_o), 64'h0);
    check("bz_exit_state", 64'(dbg_state), 64'(HTIF_DONE));

    // Timeout at 100: end_of_test flips at cycle 102
    timeout = 32'd100;
    do_reset();
    step(101);
    check("to_before", 64'(end_of_test), 64'h0);
    step(1);
    check("to_code",  64'(end_of_test), 64'hffff_ffff);
    check("to_state", 64'(dbg_state), 64'(HTIF_DONE));

    // Exit in the timeout cycle wins
    do_reset();
    step(101);
    put_store(0, TOHOST, 64'h3);
    step(1);
    clear_stores();
    check("to_exit_eot", 64'(end_of_test), 64'h3);
    timeout = '0;

    // Reset while in WAIT_RSP aborts, later response ignored
    do_reset();
    put_store(0, TOHOST, 64'h8000_4000);
    host_if.sys_req_ready_i = 1'b1;
    step(1);
    clear_stores();
    step(1);
    host_if.sys_req_ready_i = 1'b0;
    check("ra_wait", 64'(dbg_state), 64'(HTIF_WAIT_RSP));
    do_reset();
    host_if.fh_wr_ready_i = 1'b1;
    check("ra_req_data", 64'(host_if.sys_req_data_o), 64'h0);
    check("ra_busy",     64'(busy), 64'h0);
    check("ra_fh_valid", 64'(host_if.fh_wr_valid_o), 64'h0);
    host_if.sys_rsp_valid_i = 1'b1;
    host_if.sys_rsp_data_i  = 64'h55;
    step(1);
    host_if.sys_rsp_valid_i = 1'b0;
    step(1);
    check("ra_fh_after", 64'(host_if.fh_wr_valid_o), 64'h0);
    check("ra_state",    64'(dbg_state), 64'(HTIF_IDLE));
    host_if.fh_wr_ready_i = 1'b0;

    // Matching disabled with tohost address 0
    tohost_addr = '0;
    do_reset();
    put_store(0, '0, 64'h1);
    put_store(1, '0, 64'h8000_2000);
    step(1);
    clear_stores();
    check("dis_eot",       64'(end_of_test), 64'h0);
    check("dis_req_valid", 64'(host_if.sys_req_valid_o), 64'h0);
    check("dis_busy",      64'(busy), 64'h0);
    check("dis_overrun",   64'(overrun), 64'h0);

    check("fh_pending", 64'(exp_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
